alu_dispatch: RTL
=================

Name: alu_dispatch

Overview:
- Operand-supply and write-back stage sitting directly upstream of the ALU.
- Holds an 8 x 8-bit general register bank and a 4-bit status-flags register.
- Accepts one ALU command per valid/ready handshake, drives the ALU operand, op and enable inputs, captures the registered ALU result and flags, and writes the result back to the destination register.
- Also provides a load port for initialising registers and a combinational debug read port.

Parameters:
- NREGS, 8, number of general registers (power of two; index width is log2(NREGS)).
- DW, 8, data width of registers and ALU operands.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  ALU opcode: add 000, sub 001, or 010, and 011, not 100, cmp 101, shr 110, shl 111.
- cmd_dst  in  3  destination register index; also the source for operand A.
- cmd_src  in  3  register index for operand B.
- cmd_wb  in  1  write result to R[dst] (ignored for cmp).
- ld_en  in  1  register load strobe.
- ld_addr  in  3  load index.
- ld_data  in  DW  load value.
- dbg_addr  in  3  debug read index.
- dbg_data  out  DW  R[dbg_addr], combinational.
- alu_a  out  DW  to ALU in_A.
- alu_b  out  DW  to ALU in_B.
- alu_op  out  3  to ALU op.
- alu_enable_out  out  1  to ALU in_enable_out.
- alu_result  in  DW  from ALU out; registered inside the ALU, valid one edge after inputs.
- alu_flags  in  4  from ALU flags; bit 3 C, bit 2 N, bit 1 O, bit 0 Z.
- flags  out  4  latched status flags, same bit order.
- done  out  1  one-cycle pulse on command completion.

Behaviour:
- Reset (rst high at edge):
  - all registers and flags go to 0.
  - state goes to IDLE; done 0; alu_enable_out 0; alu_a, alu_b and alu_op 0.
  - cmd_ready is 0 while rst is high.
  - Reset mid-command aborts it: no write-back, no flag update, no done pulse.
- FSM states IDLE -> ISSUE -> CAPTURE -> IDLE.
- IDLE:
  - cmd_ready = 1, alu_enable_out = 0.
  - On cmd_valid & cmd_ready, latch op, dst, src and wb, then go to ISSUE.
- ISSUE:
  - drive alu_a = R[dst], alu_b = R[src], alu_op = latched op, alu_enable_out = 1.
  - the ALU registers its result at this edge; go to CAPTURE.
- CAPTURE:
  - hold alu_a, alu_b, alu_op and alu_enable_out stable.
  - At the edge, if wb = 1 and op != cmp, write R[dst] <= alu_result.
  - If op is add, sub or cmp, flags <= alu_flags; for all other ops flags are unchanged.
  - Set done = 1 for the following cycle; go to IDLE.
- Timing and throughput:
  - Latency is 3 cycles from the accept edge to the done pulse.
  - Maximum throughput is one command per 3 cycles.
  - The new command is visible in the same cycle done is high, and may be accepted in that cycle.
- Operands:
  - not, shr and shl use operand A only; alu_b is still driven with R[src].
  - If dst == src, both operands are the same register value.
- Load port:
  - ld_en is honoured only in IDLE; it is ignored in ISSUE and CAPTURE, so write-back has no conflicts.
  - If ld_en and a command accept occur in the same IDLE cycle, the load is written first. The command reads operands in ISSUE and therefore sees the loaded value.
- Arithmetic:
  - No arithmetic in this block; result and flags are taken verbatim from the ALU.
  - Register index wraps naturally within 3 bits.
- Debug port: dbg_data is combinational and reflects a write on the cycle after it occurs.

Test Plan:
- Basic add, no overflow:
  - Stimulus: load R1=0x03, R2=0x11; command add dst1 src2 wb1.
  - Required: done high exactly 3 cycles after accept; R1=0x14; flags=4'b0000.
- Add with signed overflow:
  - Stimulus: R3=0x40, R4=0x41; add dst3 src4.
  - Required: R3=0x81; flags=4'b0110 (N=1, O=1, C=0, Z=0).
- Compare:
  - Stimulus: R5=0x53, R6=0x53; cmp dst5 src6 wb1.
  - Required: R5 stays 0x53; flags Z=1.
  - Repeat with R6=0x52: Z=0.
- Logic op does not touch flags:
  - Stimulus: after the overflow test leaves flags=0110, run or with R1=0x03, R2=0x11.
  - Required: R1=0x13; flags still 0110.
  - Then shl on R1=0x53: R1=0xA6.
- Back-to-back commands and load collision:
  - Stimulus: hold cmd_valid high for two commands.
  - Required: accepts occur at cycles 0 and 3; cmd_ready is low in cycles 1-2.
  - ld_en to R1 during ISSUE is ignored (R1 unchanged).
  - ld_en plus accept in the same IDLE cycle: the op uses the loaded value.
- Reset mid-command:
  - Stimulus: assert rst during CAPTURE of an add.
  - Required: no done pulse; all registers and flags 0; alu_enable_out 0; cmd_ready returns to 1 on the cycle after rst drops.

Source files
------------

// File: rtl/alu_dispatch.sv
// alu_dispatch: operand-supply and write-back stage in front of a registered ALU.
//
// The block holds an NREGS x DW register bank and a 4-bit status-flags register.
// It runs one command per valid/ready handshake through IDLE -> ISSUE -> CAPTURE.
// In ISSUE and CAPTURE it drives the ALU. At the end of CAPTURE it writes the
// ALU result back and optionally the flags. done pulses in the following IDLE cycle.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_op, cmd_dst, cmd_src   opcode, destination (operand A) index, operand B index
//   cmd_wb                     write result to R[dst] (ignored for cmp)
//   ld_en, ld_addr, ld_data    register load port (honoured only in IDLE)
//   dbg_addr / dbg_data        combinational register read-back
//   alu_a, alu_b, alu_op       ALU operand and opcode inputs
//   alu_enable_out             ALU enable
//   alu_result, alu_flags      registered ALU outputs, flags are {C, N, O, Z}
//   flags                      latched status flags
//   done                       one-cycle completion pulse
module alu_dispatch #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src,
  input  logic          cmd_wb,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  output logic          alu_enable_out,
  input  logic [DW-1:0] alu_result,
  input  logic [3:0]    alu_flags,
  output logic [3:0]    flags,
  output logic          done
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpCmp = 3'b101;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   regs_q [NREGS];
  logic [2:0]      op_q;
  logic [AW-1:0]   dst_q;
  logic [AW-1:0]   src_q;
  logic            wb_q;
  logic [3:0]      flags_q;
  logic            done_q;

  logic            accept;
  logic            issuing;
  logic            ld_write;
  logic            wb_write;
  logic            flag_write;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (cmd_valid) state_d = StIssue;
      StIssue:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign issuing   = (state_q != StIdle);

  // Operands are read combinationally from the bank in ISSUE and CAPTURE. A load
  // that lands on the accept edge is therefore visible to the command. The bank
  // cannot change during CAPTURE, so the ALU inputs stay stable.
  assign alu_enable_out = issuing;
  assign alu_a          = issuing ? regs_q[dst_q] : '0;
  assign alu_b          = issuing ? regs_q[src_q] : '0;
  assign alu_op         = issuing ? op_q : 3'b000;

  assign ld_write   = ld_en && (state_q == StIdle);
  assign wb_write   = (state_q == StCapture) && wb_q && (op_q != OpCmp);
  assign flag_write = (state_q == StCapture) &&
                      ((op_q == OpAdd) || (op_q == OpSub) || (op_q == OpCmp));

  assign dbg_data = regs_q[dbg_addr];
  assign flags    = flags_q;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 3'b000;
      dst_q   <= '0;
      src_q   <= '0;
      wb_q    <= 1'b0;
      flags_q <= 4'b0000;
      done_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StCapture);
      if (accept) begin
        op_q  <= cmd_op;
        dst_q <= cmd_dst;
        src_q <= cmd_src;
        wb_q  <= cmd_wb;
      end
      if (flag_write) begin
        flags_q <= alu_flags;
      end
      // Loads happen only in IDLE and write-back only in CAPTURE, so at most one
      // of them is active on any edge.
      for (int i = 0; i < NREGS; i++) begin
        if (ld_write && (ld_addr == AW'(i))) begin
          regs_q[i] <= ld_data;
        end else if (wb_write && (dst_q == AW'(i))) begin
          regs_q[i] <= alu_result;
        end
      end
    end
  end

endmodule
